// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the EX-stage sequential divider: widths, handshake
// levels and the FSM state encoding.
package div_seq_ctrl_pkg;

  localparam int DIV_DATA_W   = 32;
  localparam int DIV_RESULT_W = 2 * DIV_DATA_W;
  localparam int DIV_CNT_W    = 6;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  typedef enum logic [1:0] {
    ST_FREE   = 2'b00,
    ST_BYZERO = 2'b01,
    ST_ON     = 2'b10,
    ST_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// EX-stage <-> divider request/result bundle. The master is the EX stage,
// the slave is the divider sequencer.
interface div_seq_ctrl_if
  import div_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_seq_ctrl_cond_neg.sv
// Conditional two's-complement negate; used for operand magnitudes and for
// the quotient/remainder sign fix-up.
module cond_neg #(
  parameter int W = 32
) (
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);
  assign data_o = en_i ? (~data_i + W'(1)) : data_i;
endmodule

// File: rtl/div_seq_ctrl.sv
// Radix-2 restoring DIV/DIVU sequencer with stall request and flush annul.
// Build option DIV_EARLY_EXIT_EN: finish in one cycle when |dividend| < |divisor|.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  div_seq_ctrl_if.slave     bus
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W:0]     shift_q, shift_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic                  op1_neg, op2_neg;
  logic [DATA_W-1:0]     abs1, abs2, quo_fix, rem_fix;
  logic [DATA_W:0]       diff;

  assign op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];

  cond_neg #(.W(DATA_W)) u_abs1 (.en_i(op1_neg), .data_i(bus.opdata1_i), .data_o(abs1));
  cond_neg #(.W(DATA_W)) u_abs2 (.en_i(op2_neg), .data_i(bus.opdata2_i), .data_o(abs2));

  // Quotient accumulates in the low half, partial remainder sits above it.
  cond_neg #(.W(DATA_W)) u_quo (.en_i(neg_quo_q), .data_i(shift_q[DATA_W-1:0]),
                                .data_o(quo_fix));
  cond_neg #(.W(DATA_W)) u_rem (.en_i(neg_rem_q), .data_i(shift_q[2*DATA_W:DATA_W+1]),
                                .data_o(rem_fix));

  assign diff = {1'b0, shift_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};

  // NOTE: every next-state signal gets its hold value first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      ST_FREE: begin
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = '0;
        if (bus.start_i == DIV_START && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = ST_BYZERO;
          end else begin
            state_d   = ST_ON;
            cnt_d     = '0;
            shift_d   = {{DATA_W{1'b0}}, abs1, 1'b0};
            divisor_d = abs2;
            neg_quo_d = op1_neg ^ op2_neg;
            neg_rem_d = op1_neg;
`ifdef DIV_EARLY_EXIT_EN
            // Skip the loop: remainder is the dividend, quotient is zero.
            if (abs1 < abs2) begin
              cnt_d   = CNT_W'(DATA_W);
              shift_d = {abs1, 1'b0, {DATA_W{1'b0}}};
            end
`endif
          end
        end
      end

      ST_BYZERO: begin
        if (bus.annul_i) begin
          state_d = ST_FREE;
        end else begin
          state_d  = ST_END;
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
        end
      end

      ST_ON: begin
        if (bus.annul_i) begin
          state_d = ST_FREE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          if (diff[DATA_W]) shift_d = {shift_q[2*DATA_W-1:0], 1'b0};
          else              shift_d = {diff[DATA_W-1:0], shift_q[DATA_W-1:0], 1'b1};
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d  = ST_END;
          cnt_d    = '0;
          result_d = {rem_fix, quo_fix};
          ready_d  = DIV_RESULT_READY;
        end
      end

      ST_END: begin
        if (bus.start_i == DIV_STOP) begin
          state_d  = ST_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end
      end

      default: state_d = ST_FREE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= '0;
      shift_q   <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i & ~ready_q & ~bus.annul_i;

endmodule
